// File: rtl/uart_rx_pkg.sv
// Shared encodings and constants for the UART RX control/buffer block.
package uart_rx_pkg;

  typedef enum logic {
    CFG_IDLE = 1'b0,
    CFG_PEND = 1'b1
  } cfg_state_t;

  localparam int PRESC_DEFAULT = 8;

  localparam logic EVEN = 1'b0;
  localparam logic ODD  = 1'b1;

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous first-word-fall-through FIFO; head reads as zero while empty.
module uart_rx_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 4,
  localparam int AW        = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  full,
  output logic                  empty,
  output logic [AW:0]           count
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic                  do_push;
  logic                  do_pop;

  assign full  = (count == (AW + 1)'(DEPTH));
  assign empty = (count == '0);
  assign dout  = empty ? '0 : mem[rd_ptr];

  // NOTE: every signal gets a default before the conditional, so no path infers a latch.
  always_comb begin
    do_pop  = pop & ~empty;
    do_push = push;
    if (full && !do_pop) do_push = 1'b0;
  end

  // NOTE: non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage is not reset; pointers and count alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART RX control/buffer: deferred config apply, receive FIFO, sticky
// overrun flag and saturating parity/stop error counters.
module uart_rx_ctrl
  import uart_rx_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int PRESC_W    = 6,
  parameter int CNT_W      = 8
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic                          Cfg_Wr,
  input  logic                          Cfg_PAR_EN,
  input  logic                          Cfg_PAR_TYP,
  input  logic [PRESC_W-1:0]            Cfg_Prescale,
  input  logic                          RX_Busy,
  input  logic                          Data_Valid,
  input  logic [DATA_WIDTH-1:0]         P_DATA,
  input  logic                          Parity_ERR,
  input  logic                          Stop_ERR,
  input  logic                          Stat_Clr,
  input  logic                          RD_Ready,
  output logic                          PAR_EN,
  output logic                          PAR_TYP,
  output logic [PRESC_W-1:0]            Prescale,
  output logic                          Cfg_Pending,
  output logic [DATA_WIDTH-1:0]         RD_Data,
  output logic                          RD_Valid,
  output logic [$clog2(FIFO_DEPTH):0]   FIFO_Count,
  output logic                          Overrun,
  output logic [CNT_W-1:0]              Par_Err_Cnt,
  output logic [CNT_W-1:0]              Stp_Err_Cnt
);

  cfg_state_t           state;
  logic                 sh_par_en;
  logic                 sh_par_typ;
  logic [PRESC_W-1:0]   sh_prescale;
  logic                 dv_q;
  logic                 perr_q;
  logic                 serr_q;
  logic                 push;
  logic                 pop;
  logic                 full;
  logic                 empty;
  logic                 overflow;
  logic                 perr_rise;
  logic                 serr_rise;

  // The RX core flags may stay high for several cycles; only the rising edge counts.
  assign push      = Data_Valid & ~dv_q;
  assign perr_rise = Parity_ERR & ~perr_q;
  assign serr_rise = Stop_ERR & ~serr_q;

  assign RD_Valid    = ~empty;
  assign pop         = RD_Valid & RD_Ready;
  assign overflow    = push & full & ~pop;
  assign Cfg_Pending = (state == CFG_PEND);

  uart_rx_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (FIFO_DEPTH)
  ) u_fifo (
    .clk   (CLK),
    .rst   (RST),
    .push  (push),
    .pop   (pop),
    .din   (P_DATA),
    .dout  (RD_Data),
    .full  (full),
    .empty (empty),
    .count (FIFO_Count)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      dv_q   <= 1'b0;
      perr_q <= 1'b0;
      serr_q <= 1'b0;
    end else begin
      dv_q   <= Data_Valid;
      perr_q <= Parity_ERR;
      serr_q <= Stop_ERR;
    end
  end

  // Clear has priority over any same-cycle increment or overrun.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      Overrun     <= 1'b0;
      Par_Err_Cnt <= '0;
      Stp_Err_Cnt <= '0;
    end else if (Stat_Clr) begin
      Overrun     <= 1'b0;
      Par_Err_Cnt <= '0;
      Stp_Err_Cnt <= '0;
    end else begin
      if (overflow) Overrun <= 1'b1;
      if (perr_rise && Par_Err_Cnt != {CNT_W{1'b1}}) Par_Err_Cnt <= Par_Err_Cnt + 1'b1;
      if (serr_rise && Stp_Err_Cnt != {CNT_W{1'b1}}) Stp_Err_Cnt <= Stp_Err_Cnt + 1'b1;
    end
  end

  // Config writes land in a shadow and reach the RX core only while it is idle,
  // so the active settings never change under a frame in progress.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state       <= CFG_IDLE;
      sh_par_en   <= 1'b0;
      sh_par_typ  <= EVEN;
      sh_prescale <= PRESC_W'(PRESC_DEFAULT);
      PAR_EN      <= 1'b0;
      PAR_TYP     <= EVEN;
      Prescale    <= PRESC_W'(PRESC_DEFAULT);
    end else begin
      case (state)
        CFG_IDLE: begin
          if (Cfg_Wr) begin
            sh_par_en   <= Cfg_PAR_EN;
            sh_par_typ  <= Cfg_PAR_TYP;
            sh_prescale <= Cfg_Prescale;
            state       <= CFG_PEND;
          end
        end
        CFG_PEND: begin
          if (!RX_Busy) begin
            PAR_EN   <= sh_par_en;
            PAR_TYP  <= sh_par_typ;
            Prescale <= sh_prescale;
            if (!Cfg_Wr) state <= CFG_IDLE;
          end
          if (Cfg_Wr) begin
            sh_par_en   <= Cfg_PAR_EN;
            sh_par_typ  <= Cfg_PAR_TYP;
            sh_prescale <= Cfg_Prescale;
          end
        end
        default: state <= CFG_IDLE;
      endcase
    end
  end

endmodule
